// File: rtl/conv_pkg.sv
// Shared types and size helpers for the float32 convolution sequencer.
package conv_pkg;

  localparam int unsigned FP32_W = 32;

  typedef enum logic [1:0] {StIdle, StClr, StFeed, StDrain} conv_state_e;

  function automatic int unsigned img_len(input int unsigned img_n);
    return img_n * img_n;
  endfunction

  function automatic int unsigned nres(input int unsigned img_n, input int unsigned k_n);
    return (img_n - k_n + 1) * (img_n - k_n + 1);
  endfunction

endpackage

// File: rtl/conv_res_writer.sv
// Captures datapath results into the output buffer; counts them and flags any surplus result.
module conv_res_writer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = FP32_W,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NRES   = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] out_base,
  input  logic              conv_vld,
  input  logic [DATA_W-1:0] conv_res,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        res_cnt,
  output logic [7:0]        res_cnt_nxt,
  output logic              ovf,
  output logic              err
);

  logic [ADDR_W-1:0] base_q;
  logic [7:0]        cnt_q;
  logic              wr_en_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              accept;

  assign accept      = en && conv_vld && (cnt_q < 8'(NRES));
  assign ovf         = en && conv_vld && (cnt_q >= 8'(NRES));
  assign res_cnt_nxt = accept ? cnt_q + 8'd1 : cnt_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      base_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (clr) begin
        base_q <= out_base;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end else begin
        cnt_q <= res_cnt_nxt;
        if (ovf) err_q <= 1'b1;
      end
      if (accept) begin
        wr_addr_q <= base_q + ADDR_W'(cnt_q);
        wr_data_q <= conv_res;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign res_cnt = cnt_q;
  assign err     = err_q;

endmodule

// File: rtl/conv_flt_seq.sv
// Sequencer for the float32 conv datapath: streams an IMG_N x IMG_N matrix from a sync-read
// buffer into conv_flt, stores its results and reports done/err.
module conv_flt_seq
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W    = FP32_W,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned IMG_N     = 4,
  parameter int unsigned K_N       = 3,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              conv_rst,
  output logic [DATA_W-1:0] conv_a,
  input  logic [DATA_W-1:0] conv_res,
  input  logic              conv_vld,
  input  logic              conv_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        res_cnt
);

  localparam int unsigned ImgLen = img_len(IMG_N);
  localparam int unsigned NRes   = nres(IMG_N, K_N);
  localparam int unsigned CntW   = $clog2(ImgLen + 1);
  localparam int unsigned DrnW   = $clog2(DRAIN_MAX + 1);

  conv_state_e       state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic              conv_rst_q, conv_rst_d;
  logic [DATA_W-1:0] conv_a_q, conv_a_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  // v1: read data valid on rd_data; l1/l2: that element is the last one
  logic              v1_q, v1_d, l1_q, l1_d, l2_q, l2_d;
  logic              end_seen_q, end_seen_d;
  logic [DrnW-1:0]   drain_cnt_q, drain_cnt_d;

  logic              start_ok, wr_act, read_more, wr_err, wr_ovf;
  logic [7:0]        res_cnt_nxt;

  assign start_ok  = (state_q == StIdle) && start && !abort;
  assign wr_act    = ((state_q == StFeed) || (state_q == StDrain)) && !abort;
  assign read_more = rd_cnt_q < CntW'(ImgLen);

  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_cnt_d    = rd_cnt_q;
    conv_rst_d  = conv_rst_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    v1_d        = rd_en_q;
    l1_d        = rd_en_q && (rd_cnt_q == CntW'(ImgLen));
    l2_d        = l1_q;
    conv_a_d    = v1_q ? rd_data : '0;
    end_seen_d  = end_seen_q;
    drain_cnt_d = drain_cnt_q;

    unique case (state_q)
      StIdle: begin
        conv_rst_d = 1'b1;
        if (start_ok) begin
          state_d    = StClr;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          rd_en_d    = 1'b1;
          rd_addr_d  = in_base;
          rd_cnt_d   = CntW'(1);
          end_seen_d = 1'b0;
        end
      end
      StClr, StFeed: begin
        state_d    = StFeed;
        conv_rst_d = 1'b0;
        if (read_more) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_cnt_d  = rd_cnt_q + CntW'(1);
        end
        if (state_q == StFeed) begin
          if (conv_end) begin
            end_seen_d = 1'b1;
            err_d      = 1'b1;
          end
          if (l2_q) begin
            if (end_seen_q || conv_end) begin
              state_d    = StIdle;
              busy_d     = 1'b0;
              conv_rst_d = 1'b1;
            end else begin
              state_d     = StDrain;
              drain_cnt_d = '0;
            end
          end
        end
      end
      StDrain: begin
        conv_rst_d  = 1'b0;
        drain_cnt_d = drain_cnt_q + DrnW'(1);
        if (conv_end || (drain_cnt_q == DrnW'(DRAIN_MAX - 1))) begin
          state_d    = StIdle;
          busy_d     = 1'b0;
          conv_rst_d = 1'b1;
          // A result arriving alongside conv_end still counts towards success.
          if (conv_end && (res_cnt_nxt == 8'(NRes)) && !wr_ovf && !wr_err && !err_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort && busy_q) begin
      state_d    = StIdle;
      rd_en_d    = 1'b0;
      conv_rst_d = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b1;
      v1_d       = 1'b0;
      l1_d       = 1'b0;
      l2_d       = 1'b0;
      conv_a_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      conv_rst_q  <= 1'b1;
      conv_a_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      end_seen_q  <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      conv_rst_q  <= conv_rst_d;
      conv_a_q    <= conv_a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      v1_q        <= v1_d;
      l1_q        <= l1_d;
      l2_q        <= l2_d;
      end_seen_q  <= end_seen_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  conv_res_writer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NRES  (NRes)
  ) u_writer (
    .clock      (clock),
    .rst        (rst),
    .clr        (start_ok),
    .en         (wr_act),
    .out_base   (out_base),
    .conv_vld   (conv_vld),
    .conv_res   (conv_res),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .res_cnt    (res_cnt),
    .res_cnt_nxt(res_cnt_nxt),
    .ovf        (wr_ovf),
    .err        (wr_err)
  );

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign conv_rst = conv_rst_q;
  assign conv_a   = conv_a_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q | wr_err;

endmodule
